// File: rtl/kpyd_pkg.sv
// rtl/kpyd_pkg.sv - shared keypad widths, scanner states and one-hot helper
package kpyd_pkg;

    localparam int ROW_W  = 4;
    localparam int COL_W  = 4;
    localparam int KPYD_W = ROW_W + COL_W;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        EMIT,
        WAIT_REL
    } state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/kpyd_sync.sv
// rtl/kpyd_sync.sv - multi-flop synchronizer for asynchronous level inputs
module kpyd_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/kpyd_scanner.sv
// rtl/kpyd_scanner.sv - 4x4 keypad row scanner with press/release debounce
module kpyd_scanner
    import kpyd_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic [ROW_W-1:0]  row_o,
    input  logic [COL_W-1:0]  col_i,
    output logic [KPYD_W-1:0] kpyd_o,
    output logic              valid_o,
    input  logic              ready_i
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_l_q;
    logic [COL_W-1:0]    col_s;
    logic [KPYD_W-1:0]   kpyd_q;
    logic                valid_q;

    logic cnt_inc, cnt_clr, row_rot, latch_col, load_key, drop_valid;

    kpyd_sync #(
        .WIDTH  (COL_W),
        .STAGES (SYNC_STAGES)
    ) u_col_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (col_i),
        .q_o     (col_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        row_rot    = 1'b0;
        latch_col  = 1'b0;
        load_key   = 1'b0;
        drop_valid = 1'b0;
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_clr = 1'b1;
                    // Zero or several columns (ghosting) are both treated as "nothing here".
                    if (is_onehot4(col_s)) begin
                        latch_col = 1'b1;
                        state_d   = DEB_PRESS;
                    end else begin
                        row_rot = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DEB_PRESS: begin
                if (col_s != col_l_q) begin
                    state_d = SCAN;
                    cnt_clr = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    load_key = 1'b1;
                    state_d  = EMIT;
                    cnt_clr  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            EMIT: begin
                if (valid_q && ready_i) begin
                    drop_valid = 1'b1;
                    state_d    = WAIT_REL;
                    cnt_clr    = 1'b1;
                end
            end
            WAIT_REL: begin
                if (col_s != '0) begin
                    cnt_clr = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = SCAN;
                    row_rot = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            row_q   <= ROW_W'(1);
            col_l_q <= '0;
            kpyd_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (row_rot) begin
                row_q <= {row_q[ROW_W-2:0], row_q[ROW_W-1]};
            end
            if (latch_col) begin
                col_l_q <= col_s;
            end
            if (load_key) begin
                kpyd_q  <= {col_l_q, row_q};
                valid_q <= 1'b1;
            end else if (drop_valid) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign row_o   = row_q;
    assign kpyd_o  = kpyd_q;
    assign valid_o = valid_q;

endmodule
